// File: rtl/aes_block_scheduler.sv
// Round-robin scheduler that time-shares one byte-serial AES encrypt unit among
// NREQ 128-bit requesters and returns a tagged ciphertext or a timeout error.
module aes_block_scheduler #(
   parameter int NREQ    = 2,
   parameter int IDW     = 3,
   parameter int TIMEOUT = 1023
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*128-1:0]   req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [127:0]          rsp_data,
   output logic                  rsp_err,
   output logic                  enc_valid_input,
   output logic [7:0]            enc_data_in,
   input  logic                  enc_valid_output,
   input  logic [7:0]            enc_data_out,
   output logic                  busy
);

   localparam int            TW      = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

   typedef enum logic [2:0] {IDLE, LOAD, WAIT, DRAIN, RESP} state_e;

   state_e          state_q, state_d;
   logic [IDW-1:0]  last_grant_q, last_grant_d;
   logic [127:0]    shift_q, shift_d;
   logic [127:0]    res_q, res_d;
   logic [3:0]      byte_cnt_q, byte_cnt_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [IDW-1:0]  rsp_id_q, rsp_id_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic            rsp_err_q, rsp_err_d;
   logic            enc_vi_q, enc_vi_d;
   logic [7:0]      enc_din_q, enc_din_d;
   logic            busy_q, busy_d;

   logic            grant;
   logic [IDW-1:0]  grant_idx;
   logic [127:0]    grant_data;

   // Search starts just past the last winner; reset is folded in so req_ready is 0 while held.
   always_comb begin
      req_ready  = '0;
      grant      = 1'b0;
      grant_idx  = '0;
      grant_data = '0;
      if (state_q == IDLE && reset) begin
         for (int k = 1; k <= NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
               if (!grant && req_valid[j] && (j == (int'(last_grant_q) + k) % NREQ)) begin
                  grant        = 1'b1;
                  req_ready[j] = 1'b1;
                  grant_idx    = IDW'(j);
                  grant_data   = req_data[128*j +: 128];
               end
            end
         end
      end
   end

   always_comb begin
      // NOTE: every _d defaults to its _q before the case, so no path can infer a latch.
      state_d      = state_q;
      last_grant_d = last_grant_q;
      shift_d      = shift_q;
      res_d        = res_q;
      byte_cnt_d   = byte_cnt_q;
      tmo_d        = tmo_q;
      rsp_id_d     = rsp_id_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_err_d    = rsp_err_q;
      enc_vi_d     = enc_vi_q;
      enc_din_d    = enc_din_q;

      case (state_q)
         IDLE: begin
            if (grant) begin
               state_d      = LOAD;
               last_grant_d = grant_idx;
               rsp_id_d     = grant_idx;
               rsp_err_d    = 1'b0;
               res_d        = '0;
               byte_cnt_d   = 4'd0;
               enc_vi_d     = 1'b1;
               enc_din_d    = grant_data[127:120];
               shift_d      = {grant_data[119:0], 8'h00};
            end
         end
         LOAD: begin
            byte_cnt_d = byte_cnt_q + 4'd1;
            if (byte_cnt_q == 4'd15) begin
               state_d   = WAIT;
               enc_vi_d  = 1'b0;
               enc_din_d = 8'h00;
               tmo_d     = '0;
            end else begin
               enc_din_d = shift_q[127:120];
               shift_d   = {shift_q[119:0], 8'h00};
            end
         end
         WAIT: begin
            if (enc_valid_output) begin
               state_d    = DRAIN;
               res_d      = {res_q[119:0], enc_data_out};
               byte_cnt_d = 4'd1;
               tmo_d      = '0;
            end else if (tmo_q == TMO_MAX) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               res_d       = '0;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         DRAIN: begin
            // Bubbles are skipped; each captured byte restarts the silence timer.
            if (enc_valid_output) begin
               res_d      = {res_q[119:0], enc_data_out};
               byte_cnt_d = byte_cnt_q + 4'd1;
               tmo_d      = '0;
               if (byte_cnt_q == 4'd15) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b0;
               end
            end else if (tmo_q == TMO_MAX) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               res_d       = '0;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // NOTE: shift and result registers are reset too, so no stale plaintext or ciphertext outlives a reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_grant_q <= IDW'(NREQ - 1);
         shift_q      <= '0;
         res_q        <= '0;
         byte_cnt_q   <= '0;
         tmo_q        <= '0;
         rsp_id_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         enc_vi_q     <= 1'b0;
         enc_din_q    <= '0;
         busy_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         shift_q      <= shift_d;
         res_q        <= res_d;
         byte_cnt_q   <= byte_cnt_d;
         tmo_q        <= tmo_d;
         rsp_id_q     <= rsp_id_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_err_q    <= rsp_err_d;
         enc_vi_q     <= enc_vi_d;
         enc_din_q    <= enc_din_d;
         busy_q       <= busy_d;
      end
   end

   assign rsp_valid       = rsp_valid_q;
   assign rsp_id          = rsp_id_q;
   assign rsp_data        = res_q;
   assign rsp_err         = rsp_err_q;
   assign enc_valid_input = enc_vi_q;
   assign enc_data_in     = enc_din_q;
   assign busy            = busy_q;

endmodule

// File: tb/tb_aes_block_scheduler.sv
// Bench for aes_block_scheduler: a byte-serial encrypt-unit stand-in plus a
// round-robin/latency reference model checked with immediate assertions.
module tb_aes_block_scheduler;

   localparam int NREQ    = 3;
   localparam int IDW     = 3;
   localparam int TIMEOUT = 20;
   localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic                clk = 1'b0;
   logic                reset;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*128-1:0] req_data;
   logic [NREQ-1:0]     req_ready;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [IDW-1:0]      rsp_id;
   logic [127:0]        rsp_data;
   logic                rsp_err;
   logic                enc_valid_input;
   logic [7:0]          enc_data_in;
   logic                enc_valid_output;
   logic [7:0]          enc_data_out;
   logic                busy;

   aes_block_scheduler #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .enc_valid_input(enc_valid_input), .enc_data_in(enc_data_in),
      .enc_valid_output(enc_valid_output), .enc_data_out(enc_data_out),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int vi_count = 0;
   int last_vi_cyc = 0;
   int first_out_cyc = 0;
   int model_last = NREQ - 1;
   int stub_lat = 3;
   bit stub_mute = 1'b0;
   bit stub_gap = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (enc_valid_input === 1'b1) begin
         vi_count    <= vi_count + 1;
         last_vi_cyc <= cyc;
      end
   end

   // Stand-in cipher: the real answer for the FIPS-197 vector, a fixed bijection otherwise.
   function automatic logic [127:0] cipher(input logic [127:0] pt);
      if (pt == FIPS_PT) return FIPS_CT;
      return {pt[63:0], pt[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic int rr_pick(input logic [NREQ-1:0] v);
      for (int k = 1; k <= NREQ; k++)
         if (v[(model_last + k) % NREQ]) return (model_last + k) % NREQ;
      return -1;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Encrypt-unit stand-in: gathers 16 input bytes, waits stub_lat cycles, returns 16 bytes.
   initial begin : enc_stub
      int nin;
      logic [127:0] pt_acc, ct;
      nin = 0;
      pt_acc = '0;
      enc_valid_output = 1'b0;
      enc_data_out = 8'h00;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) begin
            nin = 0;
         end else if (enc_valid_input === 1'b1) begin
            pt_acc = {pt_acc[119:0], enc_data_in};
            nin++;
            if (nin == 16) begin
               nin = 0;
               ct = cipher(pt_acc);
               if (!stub_mute) begin
                  repeat (stub_lat) @(negedge clk);
                  first_out_cyc = cyc;
                  for (int b = 0; b < 16; b++) begin
                     if (stub_gap && (b == 6 || b == 12)) begin
                        enc_valid_output = 1'b0;
                        @(negedge clk);
                     end
                     enc_valid_output = 1'b1;
                     enc_data_out = ct[127-8*b -: 8];
                     @(negedge clk);
                  end
                  enc_valid_output = 1'b0;
                  enc_data_out = 8'h00;
               end
            end
         end
      end
   end

   // Called at a negedge with the DUT idle and at least one request pending.
   task automatic one_txn(input int hold, input bit keep, output int got_id);
      int exp_id, t, vi0, exp_cyc;
      logic [NREQ-1:0] exp_oh;
      logic [127:0] exp_data;
      logic exp_err;
      #1;
      exp_id = rr_pick(req_valid);
      exp_oh = '0;
      exp_oh[exp_id] = 1'b1;
      check("grant_onehot", req_ready, exp_oh);
      exp_err  = stub_mute;
      exp_data = stub_mute ? 128'h0 : cipher(req_data[128*exp_id +: 128]);
      model_last = exp_id;
      vi0 = vi_count;
      @(negedge clk);
      if (keep) req_data[128*exp_id +: 128] = rand128();
      else req_valid[exp_id] = 1'b0;
      check("busy_in_load", busy, 1);
      t = 0;
      while (rsp_valid !== 1'b1 && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("rsp_arrives", t < 300, 1);
      // A silent unit keeps WAIT for TIMEOUT+1 cycles after the last LOAD byte.
      exp_cyc = stub_mute ? last_vi_cyc + TIMEOUT + 2 : first_out_cyc + 16 + (stub_gap ? 2 : 0);
      check("rsp_cycle", cyc, exp_cyc);
      check("enc_valid_input_cycles", vi_count - vi0, 16);
      check("rsp_id", rsp_id, exp_id);
      check("rsp_data", rsp_data, exp_data);
      check("rsp_err", rsp_err, exp_err);
      got_id = int'(rsp_id);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_rsp_valid", rsp_valid, 1);
         check("hold_rsp_data", rsp_data, exp_data);
         check("hold_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_released", rsp_valid, 0);
      check("busy_after_resp", busy, 0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int got_id, t, vi0;
      reset = 1'b0;
      rsp_ready = 1'b0;
      req_valid = '1;
      req_data = {rand128(), rand128(), rand128()};
      repeat (3) @(negedge clk);
      check("reset_req_ready", req_ready, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_enc_valid_input", enc_valid_input, 0);
      check("reset_enc_data_in", enc_data_in, 0);
      check("reset_rsp_data", rsp_data, 0);
      check("reset_rsp_id", rsp_id, 0);
      check("reset_rsp_err", rsp_err, 0);

      // FIPS-197 block from requester 0, first priority after reset.
      req_valid = 3'b001;
      req_data[127:0] = FIPS_PT;
      stub_lat = 3;
      reset = 1'b1;
      one_txn(0, 1'b0, got_id);
      check("fips_first_id", got_id, 0);

      // 50 cycles of response backpressure while requester 2 keeps asking.
      req_valid = 3'b100;
      req_data[128*2 +: 128] = rand128();
      stub_lat = 5;
      one_txn(50, 1'b1, got_id);

      // All three requesters held continuously.
      req_valid = 3'b111;
      req_data[127:0] = rand128();
      req_data[255:128] = rand128();
      for (int i = 0; i < 6; i++) begin
         stub_lat = int'($urandom_range(8, 1));
         one_txn(0, 1'b1, got_id);
         check("rr_order", got_id, i % 3);
      end
      req_valid[1] = 1'b0;
      one_txn(0, 1'b1, got_id);
      check("skip_dropped_a", got_id, 0);
      one_txn(0, 1'b1, got_id);
      check("skip_dropped_b", got_id, 2);
      req_valid = '0;

      // Silent unit, then normal service resumes.
      stub_mute = 1'b1;
      req_valid = 3'b010;
      req_data[255:128] = rand128();
      one_txn(0, 1'b0, got_id);
      stub_mute = 1'b0;
      req_valid = 3'b001;
      req_data[127:0] = rand128();
      one_txn(0, 1'b0, got_id);

      // Output bursts with bubbles before bytes 6 and 12.
      stub_gap = 1'b1;
      req_valid = 3'b100;
      req_data[128*2 +: 128] = rand128();
      one_txn(0, 1'b0, got_id);
      stub_gap = 1'b0;

      // Randomised traffic.
      for (int it = 0; it < 12; it++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
               req_data[128*i +: 128] = rand128();
               req_valid[i] = 1'b1;
            end
         end
         if (req_valid == '0) begin
            req_data[127:0] = rand128();
            req_valid[0] = 1'b1;
         end
         stub_lat = int'($urandom_range(8, 1));
         stub_gap = bit'($urandom_range(1, 0));
         one_txn(int'($urandom_range(3, 0)), bit'($urandom_range(1, 0)), got_id);
      end
      stub_gap = 1'b0;

      // Reset while byte 7 of the FIPS block is on the bus.
      req_valid = 3'b001;
      req_data[127:0] = FIPS_PT;
      stub_lat = 2;
      #1;
      vi0 = vi_count;
      t = 0;
      while (vi_count - vi0 < 8 && t < 100) begin
         @(negedge clk);
         #1;
         t++;
      end
      check("reach_load_byte7", t < 100, 1);
      check("load_byte7_value", enc_data_in, 8'h77);
      req_valid = 3'b111;
      req_data[255:128] = rand128();
      req_data[383:256] = rand128();
      reset = 1'b0;
      #1;
      check("midload_reset_enc_valid_input", enc_valid_input, 0);
      check("midload_reset_busy", busy, 0);
      check("midload_reset_req_ready", req_ready, 0);
      repeat (2) @(negedge clk);
      check("held_reset_req_ready", req_ready, 0);
      model_last = NREQ - 1;
      reset = 1'b1;
      one_txn(0, 1'b0, got_id);
      check("post_reset_first_id", got_id, 0);
      req_valid = '0;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
